// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter that shares the register file write port between ALU (A)
// and load (B) writeback, registers the winning write and bypasses both read ports.
module regfile_wr_arbiter #(
  parameter int reg_word_width = 32,
  parameter int reg_addr_width = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      A_VALID_i,
  output logic                      A_READY_o,
  input  logic [reg_addr_width-1:0] A_REG_i,
  input  logic [reg_word_width-1:0] A_DATA_i,
  input  logic                      B_VALID_i,
  output logic                      B_READY_o,
  input  logic [reg_addr_width-1:0] B_REG_i,
  input  logic [reg_word_width-1:0] B_DATA_i,
  output logic                      WRITE_EN_o,
  output logic [reg_addr_width-1:0] WRITE_REG_o,
  output logic [reg_word_width-1:0] WRITE_DATA_o,
  input  logic [reg_addr_width-1:0] READ_REG1_i,
  input  logic [reg_addr_width-1:0] READ_REG2_i,
  input  logic [reg_word_width-1:0] RF_DATA1_i,
  input  logic [reg_word_width-1:0] RF_DATA2_i,
  output logic [reg_word_width-1:0] READ_DATA1_o,
  output logic [reg_word_width-1:0] READ_DATA2_o,
  output logic [15:0]               WR_CNT_o
);

  localparam int NUM_PORTS = 2;

  logic                      last_gnt_b;  // 1: B won the most recent transfer
  logic                      xfer;
  logic                      commit;
  logic [reg_addr_width-1:0] sel_reg;
  logic [reg_word_width-1:0] sel_data;

  always_comb begin
    A_READY_o = 1'b0;
    B_READY_o = 1'b0;
    if (!RST) begin
      if (A_VALID_i && (!B_VALID_i || last_gnt_b)) A_READY_o = 1'b1;
      else if (B_VALID_i)                          B_READY_o = 1'b1;
    end
  end

  assign xfer     = A_READY_o | B_READY_o;
  assign sel_reg  = A_READY_o ? A_REG_i  : B_REG_i;
  assign sel_data = A_READY_o ? A_DATA_i : B_DATA_i;
  // Writes to r0 complete the handshake but never reach the register file.
  assign commit   = xfer && (sel_reg != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      WRITE_EN_o   <= 1'b0;
      WRITE_REG_o  <= '0;
      WRITE_DATA_o <= '0;
      WR_CNT_o     <= '0;
      last_gnt_b   <= 1'b1;
    end else begin
      WRITE_EN_o <= commit;
      if (commit) begin
        WRITE_REG_o  <= sel_reg;
        WRITE_DATA_o <= sel_data;
        WR_CNT_o     <= WR_CNT_o + 16'd1;
      end
      if (xfer) last_gnt_b <= B_READY_o;
    end
  end

  logic [NUM_PORTS-1:0][reg_addr_width-1:0] rd_reg;
  logic [NUM_PORTS-1:0][reg_word_width-1:0] rf_data;
  logic [NUM_PORTS-1:0][reg_word_width-1:0] rd_data;

  assign rd_reg  = {READ_REG2_i, READ_REG1_i};
  assign rf_data = {RF_DATA2_i, RF_DATA1_i};

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_byp
    assign rd_data[k] = (WRITE_EN_o && rd_reg[k] == WRITE_REG_o && rd_reg[k] != '0)
                        ? WRITE_DATA_o : rf_data[k];
  end

  assign READ_DATA1_o = rd_data[0];
  assign READ_DATA2_o = rd_data[1];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Vector table plus write scoreboard for regfile_wr_arbiter; hand sequences
// cover reset mid-write, last_gnt reset and counter wrap.
module tb_regfile_wr_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        A_VALID_i, B_VALID_i;
  logic        A_READY_o, B_READY_o;
  logic [4:0]  A_REG_i, B_REG_i;
  logic [31:0] A_DATA_i, B_DATA_i;
  logic        WRITE_EN_o;
  logic [4:0]  WRITE_REG_o;
  logic [31:0] WRITE_DATA_o;
  logic [4:0]  READ_REG1_i, READ_REG2_i;
  logic [31:0] RF_DATA1_i, RF_DATA2_i;
  logic [31:0] READ_DATA1_o, READ_DATA2_o;
  logic [15:0] WR_CNT_o;

  regfile_wr_arbiter #(.reg_word_width(32), .reg_addr_width(5)) dut (
    .CLK(CLK), .RST(RST),
    .A_VALID_i(A_VALID_i), .A_READY_o(A_READY_o), .A_REG_i(A_REG_i), .A_DATA_i(A_DATA_i),
    .B_VALID_i(B_VALID_i), .B_READY_o(B_READY_o), .B_REG_i(B_REG_i), .B_DATA_i(B_DATA_i),
    .WRITE_EN_o(WRITE_EN_o), .WRITE_REG_o(WRITE_REG_o), .WRITE_DATA_o(WRITE_DATA_o),
    .READ_REG1_i(READ_REG1_i), .READ_REG2_i(READ_REG2_i),
    .RF_DATA1_i(RF_DATA1_i), .RF_DATA2_i(RF_DATA2_i),
    .READ_DATA1_o(READ_DATA1_o), .READ_DATA2_o(READ_DATA2_o),
    .WR_CNT_o(WR_CNT_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    logic        ea;
    logic        eb;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  vec_t        tbl[16];
  wr_t         sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] cnt_m    = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive one request cycle, check readies, then check
  // the output stage and bypass at the following negedge.
  task automatic apply(input vec_t v);
    wr_t         e;
    logic [31:0] rf2;
    A_VALID_i = v.av; A_REG_i = v.ar; A_DATA_i = v.ad;
    B_VALID_i = v.bv; B_REG_i = v.br; B_DATA_i = v.bd;
    #1;
    chk("a_ready", {31'd0, A_READY_o}, {31'd0, v.ea});
    chk("b_ready", {31'd0, B_READY_o}, {31'd0, v.eb});
    if (v.ea && v.ar != 5'd0) begin sb.push_back('{r: v.ar, d: v.ad}); cnt_m++; end
    else if (v.eb && v.br != 5'd0) begin sb.push_back('{r: v.br, d: v.bd}); cnt_m++; end
    @(posedge CLK);
    @(negedge CLK);
    A_VALID_i = 1'b0; B_VALID_i = 1'b0;
    chk("write_en", {31'd0, WRITE_EN_o}, {31'd0, sb.size() != 0});
    if (WRITE_EN_o) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_empty actual=write_en expected=no_write");
      end else begin
        e = sb.pop_front();
        chk("write_reg", {27'd0, WRITE_REG_o}, {27'd0, e.r});
        chk("write_data", WRITE_DATA_o, e.d);
        rf2 = $urandom;
        READ_REG1_i = e.r; RF_DATA1_i = ~e.d;
        READ_REG2_i = e.r ^ 5'd1; RF_DATA2_i = rf2;
        #1;
        chk("bypass_hit", READ_DATA1_o, e.d);
        chk("bypass_miss", READ_DATA2_o, rf2);
      end
    end else begin
      rf2 = $urandom;
      READ_REG1_i = 5'd0; RF_DATA1_i = rf2;
      #1;
      chk("rd_r0_pass", READ_DATA1_o, rf2);
    end
    chk("wr_cnt", {16'd0, WR_CNT_o}, {16'd0, cnt_m});
  endtask

  initial begin
    RST = 1'b1;
    A_VALID_i = 0; A_REG_i = 0; A_DATA_i = 0;
    B_VALID_i = 0; B_REG_i = 0; B_DATA_i = 0;
    READ_REG1_i = 0; READ_REG2_i = 0; RF_DATA1_i = 0; RF_DATA2_i = 0;

    tbl[0]  = '{1, 5'd1,  32'd12,    0, 5'd0,  32'd0,     1, 0};
    tbl[1]  = '{0, 5'd0,  32'd0,     1, 5'd2,  32'd5,     0, 1};
    tbl[2]  = '{1, 5'd16, 32'd13,    1, 5'd31, 32'd14,    1, 0};
    tbl[3]  = '{0, 5'd0,  32'd0,     1, 5'd31, 32'd14,    0, 1};
    for (int i = 0; i < 6; i++)
      tbl[4+i] = '{1, 5'd3, 32'h100 + i, 1, 5'd4, 32'h200 + i, (i % 2) == 0, (i % 2) == 1};
    tbl[10] = '{1, 5'd5,  32'h55,    1, 5'd5,  32'h66,    1, 0};
    tbl[11] = '{0, 5'd0,  32'd0,     1, 5'd5,  32'h66,    0, 1};
    tbl[12] = '{0, 5'd0,  32'd0,     1, 5'd0,  32'd11,    0, 1};
    tbl[13] = '{1, 5'd0,  32'h99,    0, 5'd0,  32'd0,     1, 0};
    tbl[14] = '{0, 5'd0,  32'd0,     0, 5'd0,  32'd0,     0, 0};
    tbl[15] = '{1, 5'd20, 32'hCAFE,  0, 5'd0,  32'd0,     1, 0};

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    A_VALID_i = 1; B_VALID_i = 1;
    #1;
    chk("rst_a_ready", {31'd0, A_READY_o}, 32'd0);
    chk("rst_b_ready", {31'd0, B_READY_o}, 32'd0);
    chk("rst_write_en", {31'd0, WRITE_EN_o}, 32'd0);
    chk("rst_write_reg", {27'd0, WRITE_REG_o}, 32'd0);
    chk("rst_write_data", WRITE_DATA_o, 32'd0);
    chk("rst_wr_cnt", {16'd0, WR_CNT_o}, 32'd0);
    A_VALID_i = 0; B_VALID_i = 0;
    RST = 1'b0;

    for (int i = 0; i < 16; i++) apply(tbl[i]);

    // Reset while a write sits in the output stage; valids high during reset.
    apply('{1, 5'd7, 32'd77, 0, 5'd0, 32'd0, 1, 0});
    RST = 1'b1;
    A_VALID_i = 1; A_REG_i = 5'd8; B_VALID_i = 1; B_REG_i = 5'd9;
    #1;
    chk("rst_mid_a_ready", {31'd0, A_READY_o}, 32'd0);
    chk("rst_mid_b_ready", {31'd0, B_READY_o}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid_write_en", {31'd0, WRITE_EN_o}, 32'd0);
    chk("rst_mid_wr_cnt", {16'd0, WR_CNT_o}, 32'd0);
    chk("rst_mid_write_reg", {27'd0, WRITE_REG_o}, 32'd0);
    RST = 1'b0; A_VALID_i = 0; B_VALID_i = 0;
    sb.delete();
    cnt_m = 16'd0;

    // last_gnt resets to B, so A wins even though A won just before reset.
    apply('{1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 1, 0});
    apply('{0, 5'd0,  32'd0,  1, 5'd11, 32'hB0, 0, 1});

    // Fill the counter up to 0xFFFF with back-to-back A-only writes.
    A_VALID_i = 1; A_REG_i = 5'd1; A_DATA_i = 32'h1;
    repeat (int'(16'hFFFF - cnt_m)) @(posedge CLK);
    @(negedge CLK);
    A_VALID_i = 0;
    cnt_m = 16'hFFFF;
    chk("cnt_preload", {16'd0, WR_CNT_o}, {16'd0, cnt_m});
    apply('{1, 5'd2, 32'hF00D, 0, 5'd0, 32'd0, 1, 0});
    chk("cnt_wrap", {16'd0, WR_CNT_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters: A (ALU writeback) and B (load unit).
- Arbitrates round-robin over valid/ready handshakes and registers the winning write into an output stage that drives the register file write port directly.
- Provides a one-deep bypass for both register file read ports, so a read of a register being written in the current cycle returns the new value.
- Counts committed writes.

Parameters:
- reg_word_width, 32, data word width.
- reg_addr_width, 5, register address width (2^reg_addr_width registers).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- A_VALID_i  input  1  requester A has a write pending.
- A_READY_o  output  1  requester A's write is accepted this cycle.
- A_REG_i  input  reg_addr_width  requester A destination register.
- A_DATA_i  input  reg_word_width  requester A write data.
- B_VALID_i, B_READY_o, B_REG_i, B_DATA_i  same as A, for requester B.
- WRITE_EN_o  output  1  drives the register file write enable.
- WRITE_REG_o  output  reg_addr_width  drives the register file write address.
- WRITE_DATA_o  output  reg_word_width  drives the register file write data.
- READ_REG1_i, READ_REG2_i  input  reg_addr_width  current register file read addresses.
- RF_DATA1_i, RF_DATA2_i  input  reg_word_width  raw register file read data.
- READ_DATA1_o, READ_DATA2_o  output  reg_word_width  read data after bypass.
- WR_CNT_o  output  16  number of committed writes (wraps).

Behaviour:
- Clock and reset:
  - Single clock, CLK.
  - RST is synchronous and active-high; it takes effect only on a CLK rising edge.
- Reset values (after a clock edge with RST=1):
  - WRITE_EN_o=0, WRITE_REG_o=0, WRITE_DATA_o=0, WR_CNT_o=0.
  - last_gnt=B, so A wins the first contention.
  - While RST=1, A_READY_o=B_READY_o=0 and no request is accepted.
- Handshake:
  - A transfer occurs on a rising edge when VALID_i=1 and READY_o=1.
  - READY_o is combinational from the VALID inputs and last_gnt.
  - A requester must hold REG/DATA stable while VALID_i=1 and READY_o=0.
- Arbitration, evaluated each cycle:
  - Neither valid: no grant.
  - One valid: grant it.
  - Both valid: grant the one that is not last_gnt.
  - At most one READY_o is high in any cycle.
  - last_gnt updates to the granted requester on every transfer; it is unchanged when there is no grant.
- Output stage (latency: accept edge N, WRITE_EN_o=1 during cycle N+1, register file writes at edge N+1):
  - On a transfer with REG != 0: WRITE_EN_o<=1, WRITE_REG_o<=REG, WRITE_DATA_o<=DATA.
  - On a transfer with REG == 0: the transfer completes (READY_o was high) but WRITE_EN_o<=0. The write is discarded and not counted.
  - No transfer: WRITE_EN_o<=0. WRITE_REG_o and WRITE_DATA_o hold their values.
  - The stage never stalls, so back-to-back transfers are allowed every cycle.
- Write counter:
  - WR_CNT_o increments by 1 on every edge where the output stage loads WRITE_EN_o=1.
  - Wraps from 0xFFFF to 0x0000.
- Bypass (combinational, per read port k):
  - If WRITE_EN_o=1, READ_REGk_i == WRITE_REG_o and READ_REGk_i != 0, then READ_DATAk_o = WRITE_DATA_o.
  - Otherwise READ_DATAk_o = RF_DATAk_i.
  - Reads of register 0 always pass RF_DATAk_i.
- Same-address contention:
  - When A and B both target the same register, the granted write commits first and the other commits in the following cycle.
  - The final register value is the later write's data.
- Reset mid-operation:
  - The in-flight output-stage write is dropped (WRITE_EN_o=0 after the reset edge).
  - Requests that were not accepted remain the requester's responsibility.

Test Plan:
- Reset, then A only: A_VALID=1, A_REG=1, A_DATA=12 -> A_READY=1 at cycle 0; next cycle WRITE_EN=1, WRITE_REG=1, WRITE_DATA=12; WR_CNT=1.
- Contention: A (reg 16, 13) and B (reg 31, 14) both held valid -> A granted first, B the next cycle; WRITE_REG sequence 16, 31; WR_CNT=2; last_gnt=B.
- Sustained contention over 6 cycles -> grants alternate A,B,A,B,A,B; no READY_o overlap; WR_CNT=6.
- Register 0 write: B_REG=0, B_DATA=11 -> B_READY=1, WRITE_EN stays 0, WR_CNT unchanged; READ_REG1=0 returns RF_DATA1.
- Bypass: commit A reg 16 = 13 with READ_REG1=16, RF_DATA1=0 during the write cycle -> READ_DATA1=13; READ_REG2=1 -> READ_DATA2=RF_DATA2.
- Reset mid-write plus counter wrap: assert RST in the cycle WRITE_EN=1 -> next cycle WRITE_EN=0 and WR_CNT=0; separately, preload 0xFFFF writes and commit one more -> WR_CNT=0x0000.
